ha_serial_accum: RTL and testbench
==================================

Name: ha_serial_accum

Overview:
- Downstream consumer of the half-adder stage that drives z = y & x and w = y ^ x each cycle.
- Treats the incoming (z, w) pairs as the carry/sum of two operands presented bit-serially, LSB first.
- Adds the missing carry-chain register to complete a bit-serial full adder, then deserializes the result into a WIDTH-bit word.
- Hands the word out on a valid/ready handshake, together with the final carry-out.

Parameters:
- WIDTH, 8, operand/result width in bits; also the fixed frame length in cycles (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_z  input  1  half-adder carry bit (y & x) for the current bit position.
- i_w  input  1  half-adder sum bit (y ^ x) for the current bit position.
- i_valid  input  1  i_z/i_w carry a valid bit this cycle.
- i_first  input  1  qualifies the bit as bit 0 (LSB) of a new frame; meaningful only with i_valid.
- o_bit_ready  output  1  block accepts a bit this cycle.
- o_sum  output  WIDTH  assembled result word.
- o_carry  output  1  carry-out of the MSB.
- o_valid  output  1  o_sum/o_carry valid.
- i_ready  input  1  downstream accepts the result.
- o_frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: o_valid=0, o_sum=0, o_carry=0, o_frame_err=0, state=IDLE, carry register c=0, bit counter=0, shift register=0.
- Bit acceptance: a bit is accepted when i_valid & o_bit_ready.
  - o_bit_ready = ~o_valid | i_ready (combinational).
  - A result being popped in the same cycle frees the slot, so frames stream back-to-back with no gap.
- Per accepted bit:
  - s = i_w ^ c; c_next = i_z | (i_w & c).
  - s shifts into the shift register at the MSB end, so after WIDTH bits bit 0 sits at the LSB.
  - If i_z = i_w = 1 (illegal from a half adder), the formulas are still applied unchanged; no error is raised.
- State machine:
  - IDLE:
    - Accepted bit with i_first=1: c starts at 0, s = i_w, c = i_z, counter=1, go to ACC.
    - Accepted bit with i_first=0: bit dropped, o_frame_err pulses, stay IDLE.
  - ACC:
    - Accepted bit with i_first=0: process the bit, counter += 1.
    - When the WIDTH-th bit is accepted: next cycle o_sum = assembled word, o_carry = c_next, o_valid=1, counter=0, c=0, go to IDLE.
    - Accepted bit with i_first=1: o_frame_err pulses, the partial frame is discarded, and this bit restarts a frame as bit 0 (counter=1, remain ACC).
    - Cycles without an accepted bit: hold all state (bubbles allowed anywhere in a frame).
- Latency: o_valid rises the cycle after the last bit is accepted.
- Output hold: o_valid stays high and o_sum/o_carry stay stable until i_ready=1.
  - o_valid & i_ready with no completing bit: o_valid falls next cycle.
  - o_valid & i_ready with a completing bit in the same cycle: o_valid stays 1 and the new word is loaded.
- Reset mid-frame or mid-hold: everything returns to reset values next cycle; the partial frame and any pending result are lost.
- Counter width: $clog2(WIDTH+1); wraps only through the end-of-frame reset to 0.

Optional Feature:
- Macro: ASVI_HA_SATURATE_EN.
- Defined: when the final carry-out is 1, o_sum is loaded with all ones; o_carry still reports 1.
- Undefined: o_sum is the modulo-2^WIDTH sum; o_carry reports the overflow.

Test Plan:
- Basic add: WIDTH=8, bench streams (z=a&b, w=a^b) LSB-first for a=0x35, b=0x4A, i_first on bit 0, i_ready=1 -> one cycle after bit 7: o_valid=1, o_sum=0x7F, o_carry=0.
- Carry ripple: a=0xFF, b=0x01 -> o_sum=0x00, o_carry=1 (0xFF with o_carry=1 when ASVI_HA_SATURATE_EN is defined).
- Backpressure: a=0x12, b=0x34, i_ready=0 for 5 cycles after o_valid, second frame offered -> o_sum=0x46 held stable, o_bit_ready=0, no second-frame bits accepted; on i_ready=1 the second frame proceeds.
- Back-to-back with bubbles: two frames (0x01+0x01, 0x80+0x80) with i_valid low on random cycles and i_ready=1 -> results 0x02/c=0, then 0x00/c=1, in order, with no lost bits.
- Framing errors:
  - 3 bits then i_first reasserted -> o_frame_err pulses once, result equals the second frame only.
  - Valid bit without i_first in IDLE -> o_frame_err pulses, bit dropped.
- Reset mid-frame: rst=1 after 4 bits -> all outputs 0 next cycle; a following full frame 0x0F+0x01 gives 0x10, c=0.

Source files
------------

// File: rtl/ha_serial_accum.sv
// ---------------------------------------------------------------------------
// ha_serial_accum
//
// Completes a bit-serial full adder behind a half-adder stage. Each cycle the
// upstream stage presents z = x & y (carry) and w = x ^ y (sum) for one bit
// position, LSB first. This block keeps the running carry, deserializes the
// sum bits into a WIDTH-bit word and offers the word plus the final carry-out
// on a valid/ready handshake.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   i_z, i_w     half-adder carry / sum bit for the current position
//   i_valid      i_z/i_w hold a bit this cycle
//   i_first      bit is bit 0 of a new frame (qualified by i_valid)
//   o_bit_ready  a bit is accepted this cycle when i_valid is also high
//   o_sum        assembled result word
//   o_carry      carry-out of the MSB
//   o_valid      o_sum/o_carry hold a result
//   i_ready      downstream takes the result this cycle
//   o_frame_err  one-cycle pulse on a framing violation
//
// Build option
//   ASVI_HA_SATURATE_EN : when defined, a result with carry-out 1 loads
//                         o_sum with all ones (o_carry still reports 1).
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in progress; only a bit with i_first starts one
// ACC   | collecting bits 1..WIDTH-1 of the current frame
// ---------------------------------------------------------------------------
module ha_serial_accum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_z,
    input  logic             i_w,
    input  logic             i_valid,
    input  logic             i_first,
    output logic             o_bit_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only WIDTH-1 bits are stored: the final bit goes straight into o_sum.
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    logic             accept;
    logic             restart;
    logic             c_in;
    logic             s_bit;
    logic             c_nx;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] word;

    // A result being popped frees the slot in the same cycle.
    assign o_bit_ready = ~valid_q | i_ready;
    assign accept      = i_valid & o_bit_ready;
    assign restart     = accept & i_first;

    // A frame start always begins from a cleared carry, whatever c_q holds.
    assign c_in   = restart ? 1'b0 : c_q;
    assign s_bit  = i_w ^ c_in;
    assign c_nx   = i_z | (i_w & c_in);
    assign cnt_nx = restart ? CW'(1) : cnt_q + CW'(1);
    assign word   = {s_bit, sh_q};

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (i_first) begin
                        state_d = ACC;
                        c_d     = c_nx;
                        cnt_d   = cnt_nx;
                        sh_d    = word[WIDTH-1:1];
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
                ACC: begin
                    // i_first mid-frame: partial frame is discarded and this
                    // bit is taken as bit 0 through restart/c_in/cnt_nx.
                    ferr_d = i_first;
                    if (cnt_nx == CW'(WIDTH)) begin
`ifdef ASVI_HA_SATURATE_EN
                        sum_d = c_nx ? {WIDTH{1'b1}} : word;
`else
                        sum_d = word;
`endif
                        carry_d = c_nx;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        c_d     = 1'b0;
                        sh_d    = word[WIDTH-1:1];
                        state_d = IDLE;
                    end else begin
                        c_d     = c_nx;
                        cnt_d   = cnt_nx;
                        sh_d    = word[WIDTH-1:1];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_sum       = sum_q;
    assign o_carry     = carry_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_ha_serial_accum.sv
// ---------------------------------------------------------------------------
// Bench for ha_serial_accum (WIDTH = 8). Expected results are plain integer
// additions of the operand pairs, queued in frame order and popped whenever
// the bench sees a result handshake.
// ---------------------------------------------------------------------------
module tb_ha_serial_accum;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_z, i_w, i_valid, i_first, i_ready;
    logic         o_bit_ready, o_carry, o_valid, o_frame_err;
    logic [W-1:0] o_sum;

    int vec  = 0;
    int miss = 0;
    int err_cnt = 0;
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;
    bit         mon_en = 1'b0;
    bit         rdone;

    ha_serial_accum #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_z         (i_z),
        .i_w         (i_w),
        .i_valid     (i_valid),
        .i_first     (i_first),
        .o_bit_ready (o_bit_ready),
        .o_sum       (o_sum),
        .o_carry     (o_carry),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Result scoreboard and frame-error counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (o_frame_err) err_cnt++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(o_sum), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result_sum", 32'(o_sum), 32'(mon_e[W-1:0]));
                    chk("result_carry", 32'(o_carry), 32'(mon_e[W]));
                end
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b};
`ifdef ASVI_HA_SATURATE_EN
        if (r[W]) r[W-1:0] = '1;
`endif
        return r;
    endfunction

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a bit on the inputs until it is accepted (bounded).
    task automatic put_bit(input logic z, input logic w, input logic f);
        bit ok;
        int t;
        i_z = z; i_w = w; i_first = f; i_valid = 1'b1;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = o_bit_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) chk("bit_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int n, input int bub_pct);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < bub_pct) idle($urandom_range(1, 3));
            put_bit(a[i] & b[i], a[i] ^ b[i], i == 0);
        end
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input int bub_pct);
        exp_q.push_back(model(a, b));
        send_bits(a, b, W, bub_pct);
    endtask

    initial begin
        int e0;
        logic [W-1:0] ra, rb;
        rst = 1'b1; i_z = 0; i_w = 0; i_valid = 0; i_first = 0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_sum", 32'(o_sum), 32'd0);
        chk("reset_carry", 32'(o_carry), 32'd0);
        chk("reset_ferr", 32'(o_frame_err), 32'd0);
        chk("reset_bit_ready", 32'(o_bit_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic add and one-cycle latency
        send_frame(8'h35, 8'h4A, 0);
        @(negedge clk);
        chk("basic_valid", 32'(o_valid), 32'd1);
        chk("basic_sum", 32'(o_sum), 32'h7F);
        chk("basic_carry", 32'(o_carry), 32'd0);
        @(posedge clk); #1;
        idle(2);

        // Carry ripple through every bit
        send_frame(8'hFF, 8'h01, 0);
        @(negedge clk);
`ifdef ASVI_HA_SATURATE_EN
        chk("ripple_sum", 32'(o_sum), 32'hFF);
`else
        chk("ripple_sum", 32'(o_sum), 32'h00);
`endif
        chk("ripple_carry", 32'(o_carry), 32'd1);
        @(posedge clk); #1;
        idle(2);

        // Backpressure: result held, next frame stalled
        i_ready = 1'b0;
        send_frame(8'h12, 8'h34, 0);
        i_z = 1'b0; i_w = 1'b0; i_first = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_sum", 32'(o_sum), 32'h46);
            chk("bp_bit_ready", 32'(o_bit_ready), 32'd0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        send_frame(8'h56, 8'h78, 0);
        idle(3);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with bubbles
        send_frame(8'h01, 8'h01, 30);
        send_frame(8'h80, 8'h80, 30);
        idle(3);
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Framing error: restart after 3 bits
        e0 = err_cnt;
        send_bits(8'hAA, 8'h55, 3, 0);
        send_frame(8'h21, 8'h42, 0);
        idle(3);
        chk("restart_ferr_count", 32'(err_cnt), 32'(e0 + 1));
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        // Framing error: stray bit in IDLE is dropped
        e0 = err_cnt;
        put_bit(1'b0, 1'b1, 1'b0);
        idle(2);
        chk("idle_ferr_count", 32'(err_cnt), 32'(e0 + 1));
        send_frame(8'h03, 8'h04, 0);
        idle(3);
        chk("idle_drop_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame
        e0 = err_cnt;
        send_bits(8'hC3, 8'h3C, 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", 32'(o_valid), 32'd0);
        chk("rstmid_sum", 32'(o_sum), 32'd0);
        chk("rstmid_carry", 32'(o_carry), 32'd0);
        chk("rstmid_ferr", 32'(o_frame_err), 32'd0);
        @(posedge clk); #1;
        send_frame(8'h0F, 8'h01, 0);
        @(negedge clk);
        chk("rstmid_sum_after", 32'(o_sum), 32'h10);
        chk("rstmid_carry_after", 32'(o_carry), 32'd0);
        @(posedge clk); #1;
        idle(2);
        chk("rstmid_no_ferr", 32'(err_cnt), 32'(e0));

        // Random operands, random bubbles, random downstream stalls
        rdone = 1'b0;
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    send_frame(ra, rb, 25);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    i_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        i_ready = 1'b1;
        idle(5);
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_no_ferr", 32'(err_cnt), 32'(e0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
